// File: rtl/divisor_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divisor_pkg;

    localparam int N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_passo.sv
// One combinational restoring-division step: shift {R,Q} left, then subtract DREG if it fits.
module divisor_passo
    import divisor_pkg::*;
#(
    parameter int N = divisor_pkg::N
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] dreg,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N:0] r_sh_s;
    logic [N:0] d_ext_s;
    logic       fits_s;

    // R stays below DREG between steps, so its MSB is zero and the shift loses nothing
    always_comb begin
        r_sh_s  = {r[N-1:0], q[N-1]};
        d_ext_s = {1'b0, dreg};
        fits_s  = (r_sh_s >= d_ext_s);
        if (fits_s) begin
            r_next = r_sh_s - d_ext_s;
        end else begin
            r_next = r_sh_s;
        end
        q_next = {q[N-2:0], fits_s};
    end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock,
// using the St/Idle/Done handshake shared with the shift-add multiplier.
module divisor_sequencial #(
    parameter int N = divisor_pkg::N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           St,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quociente,
    output logic [N-1:0]   Resto,
    output logic           Idle,
    output logic           Done,
    output logic           Overflow
);

    import divisor_pkg::*;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   dreg_r;
    logic [N:0]     r_r;
    logic [N-1:0]   q_r;
    logic [N:0]     r_next_s;
    logic [N-1:0]   q_next_s;
    logic [N-1:0]   hi_s;
    logic           ovf_s;

    divisor_passo #(.N(N)) u_passo (
        .r      (r_r),
        .q      (q_r),
        .dreg   (dreg_r),
        .r_next (r_next_s),
        .q_next (q_next_s)
    );

    // Quotient would not fit in N bits (or divide by zero) when the upper half is not below the divisor
    always_comb begin
        hi_s  = Dividendo[2*N-1:N];
        ovf_s = (Divisor == {N{1'b0}}) || (hi_s >= Divisor);
    end

    // Control FSM, step counter, datapath registers and registered handshake outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            dreg_r    <= {N{1'b0}};
            r_r       <= {(N+1){1'b0}};
            q_r       <= {N{1'b0}};
            Quociente <= {N{1'b0}};
            Resto     <= {N{1'b0}};
            Idle      <= 1'b1;
            Done      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (St) begin
                        dreg_r <= Divisor;
                        Idle   <= 1'b0;
                        if (ovf_s) begin
                            Overflow <= 1'b1;
                            Done     <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            r_r      <= {1'b0, hi_s};
                            q_r      <= Dividendo[N-1:0];
                            cnt_r    <= {CW{1'b0}};
                            Overflow <= 1'b0;
                            state_r  <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_r   <= r_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_STEP) begin
                        Quociente <= q_next_s;
                        Resto     <= r_next_s[N-1:0];
                        Done      <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    Done    <= 1'b0;
                    Idle    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    Done    <= 1'b0;
                    Idle    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
- Sequential restoring divider; the inverse operation of the team's 16x16 shift-add multiplier.
- Divides a 2N-bit dividend by an N-bit divisor, one quotient bit per clock.
- Produces an N-bit quotient and an N-bit remainder.
- Uses the same St/Idle/Done handshake as the multiplier, so the CPU's MULT/DIV control uses one protocol for both units.

Parameters:
- N, 16, operand width. Dividend is 2N bits; quotient and remainder are N bits each.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- St  input  1  start request; sampled only while Idle=1.
- Dividendo  input  2N  dividend; captured at the start edge.
- Divisor  input  N  divisor; captured at the start edge.
- Quociente  output  N  quotient; registered.
- Resto  output  N  remainder; registered.
- Idle  output  1  high when the unit can accept St.
- Done  output  1  high for exactly one cycle when a result is valid.
- Overflow  output  1  high with Done when the division was not performed.

Behaviour:
- Reset (synchronous, active-high; any state, including mid-division):
  - State goes to IDLE; counter goes to 0.
  - Quociente=0, Resto=0, Idle=1, Done=0, Overflow=0.
- State IDLE (Idle=1):
  - On an edge with St=1, capture Divisor into DREG.
  - Overflow check: Divisor==0, or Dividendo[2N-1:N] >= Divisor.
    - If true, go to DONE with Overflow=1. Quociente and Resto keep their previous values.
    - If false, load R (N+1 bits) = {0, Dividendo[2N-1:N]} and Q = Dividendo[N-1:0]. Set counter=0, clear Overflow, go to CALC.
- State CALC (Idle=0):
  - Each edge performs one restoring step:
    - {R,Q} shifted left by 1.
    - If the shifted R >= DREG: R = R - DREG and Q[0] = 1; otherwise Q[0] = 0.
  - R never exceeds N+1 bits, because the upper half was checked below DREG at start.
  - Counter increments each step. The edge that completes step N writes Quociente=Q and Resto=R[N-1:0], then goes to DONE.
  - St is ignored in CALC.
- State DONE (Idle=0):
  - Done=1 for this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - Start edge = edge 0. Normal division: Done is high during the cycle after edge N (16 for N=16).
  - Overflow case: Done is high during the cycle after edge 0.
  - Period from start to accepting the next St: N+2 edges.
- Back-to-back: if St is held high, a new division starts on the first edge after DONE, re-sampling the operands on that edge.
- Output hold: Quociente, Resto and Overflow stay stable from Done until the next result. They are not cleared when a new start is accepted; Overflow only is cleared at a non-overflow start.
- Operand changes after the start edge have no effect.
- Unsigned arithmetic only. Counter width is clog2(N+1).

Decomposition:
- Package divisor_pkg:
  - State encoding constants IDLE, CALC, DONE (2 bits).
  - Default width constant N=16.
- One natural sub-module, divisor_passo: a combinational single restoring step.
  - Inputs: R, Q, DREG.
  - Outputs: next R, next Q.
  - Instantiated once; the FSM/counter lives in the top module.

Test Plan:
- Reset pulse, then idle -> Idle=1, Done=0, Quociente=0, Resto=0, Overflow=0.
- Dividendo=100000, Divisor=7, St one cycle -> Done in the cycle after edge 16; Quociente=14285, Resto=5, Overflow=0; Done exactly one cycle, then Idle=1.
- Dividendo=0xFFFE0001, Divisor=0xFFFF -> Quociente=0xFFFF, Resto=0; Dividendo=0x0000FFFF, Divisor=1 -> Quociente=0xFFFF, Resto=0.
- Dividendo=0x00070000, Divisor=7, then Divisor=0 -> Done in the cycle after the start edge with Overflow=1; Quociente and Resto unchanged from the prior result.
- Start 1000/3, assert Reset at edge 8 of CALC -> next cycle Idle=1, all outputs at reset values, no Done. A following 1000/3 gives Quociente=333, Resto=1.
- St held high with operands changed during CALC -> changes ignored. Second division starts on the edge after DONE using the operands present at that edge; both results are checked against a software reference.
